// File: rtl/cr_gray2bin_pipe.sv
// cr_gray2bin_pipe: pipelined Gray-to-binary decoder with valid/ready flow
// control and a per-word step-error tag (Hamming distance > 1 between
// consecutive accepted words).
//
// Ports
//   Clk       clock, rising edge
//   Rst       synchronous active-high reset
//   InValid   G holds a word; transfer when InValid && InReady
//   InReady   decoder can accept (combinational from OutReady and valid bits)
//   G         Gray-code input word
//   OutValid  B/StepErr hold a decoded word; transfer when OutValid && OutReady
//   OutReady  sink accepts
//   B         binary output word
//   StepErr   accepted word differed from the previous accepted word by >1 bit
module cr_gray2bin_pipe #(
  parameter int unsigned pWidth  = 4,
  parameter int unsigned pStages = 2,
  parameter bit          pCheck  = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [pWidth-1:0] G,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [pWidth-1:0] B,
  output logic              StepErr
);

  // Bits resolved per stage (the last stage takes whatever remains).
  localparam int unsigned Chunk = (pWidth + pStages - 1) / pStages;

  // Lowest bit index that is fully decoded after stage k; stage -1 means none.
  function automatic int lo_bit(input int k);
    if (k < 0) return int'(pWidth);
    if (k >= int'(pStages) - 1) return 0;
    if (int'(pWidth) > (k + 1) * int'(Chunk)) return int'(pWidth) - (k + 1) * int'(Chunk);
    return 0;
  endfunction

  logic [pStages-1:0] vld;
  logic [pStages-1:0] err;
  logic [pStages-1:0] en;
  logic [pWidth-1:0]  dat [pStages];

  logic [pWidth-1:0]  hist;
  logic               hist_v;
  logic               acc_c;
  logic               step_c;

  // Stage k may load when any stage from k to the end is empty, or the sink
  // takes the last word; written without a stage-to-stage chain.
  always_comb begin
    for (int k = 0; k < int'(pStages); k++) begin
      en[k] = OutReady;
      for (int j = k; j < int'(pStages); j++) begin
        if (!vld[j]) en[k] = 1'b1;
      end
    end
  end

  assign InReady = !Rst && en[0];
  assign acc_c   = InValid && InReady;

  // Step check against the previous accepted word, evaluated at acceptance.
  assign step_c = pCheck && hist_v && ($countones(G ^ hist) > 1);

  // History of the last accepted word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hist   <= '0;
      hist_v <= 1'b0;
    end else if (acc_c) begin
      hist   <= G;
      hist_v <= 1'b1;
    end
  end

  for (genvar k = 0; k < int'(pStages); k++) begin : g_stage
    localparam int lo_idx = lo_bit(k);
    localparam int hi_idx = lo_bit(k - 1);

    logic [pWidth-1:0] din;
    logic [pWidth-1:0] dec;
    logic              vin;
    logic              ein;
    logic [pWidth-1:0] d_q;
    logic              v_q;
    logic              e_q;

    if (k == 0) begin : g_first
      assign din = G;
      assign vin = acc_c;
      assign ein = step_c;
    end else begin : g_next
      assign din = dat[k-1];
      assign vin = vld[k-1];
      assign ein = err[k-1];
    end

    // Resolve this stage's bit slice; bits above it arrive already decoded,
    // so the running XOR prefix is simply the next higher output bit.
    always_comb begin
      dec = din;
      for (int i = int'(pWidth) - 2; i >= 0; i--) begin
        if (i >= lo_idx && i < hi_idx) dec[i] = din[i] ^ dec[i+1];
      end
    end

    // Data only loads with a valid word so idle input never reaches B.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        v_q <= 1'b0;
        d_q <= '0;
        e_q <= 1'b0;
      end else if (en[k]) begin
        v_q <= vin;
        if (vin) begin
          d_q <= dec;
          e_q <= ein;
        end
      end
    end

    assign vld[k] = v_q;
    assign err[k] = e_q;
    assign dat[k] = d_q;
  end

  assign OutValid = vld[pStages-1];
  assign B        = dat[pStages-1];
  assign StepErr  = err[pStages-1];

endmodule

// File: tb/tb_cr_gray2bin_pipe.sv
// tb_cr_gray2bin_pipe: drives four decoder instances (W4/S2, W8/S1, W8/S3,
// W8/S8) and checks them against a word-level queue model.
module tb_cr_gray2bin_pipe;

  localparam int ND = 4;

  typedef struct packed {
    logic [15:0] at;
    logic        lat;
    logic        err;
    logic [7:0]  b;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [ND];
  logic       ir   [ND];
  logic [7:0] g    [ND];
  logic       ov   [ND];
  logic       ordy [ND];
  logic [7:0] bo   [ND];
  logic       se   [ND];
  logic [3:0] b4;

  always #5 clk = ~clk;

  assign bo[0] = {4'h0, b4};

  cr_gray2bin_pipe #(.pWidth(4), .pStages(2), .pCheck(1'b1)) u_w4s2 (
    .Clk(clk), .Rst(rst), .InValid(iv[0]), .InReady(ir[0]), .G(g[0][3:0]),
    .OutValid(ov[0]), .OutReady(ordy[0]), .B(b4), .StepErr(se[0]));
  cr_gray2bin_pipe #(.pWidth(8), .pStages(1), .pCheck(1'b1)) u_w8s1 (
    .Clk(clk), .Rst(rst), .InValid(iv[1]), .InReady(ir[1]), .G(g[1]),
    .OutValid(ov[1]), .OutReady(ordy[1]), .B(bo[1]), .StepErr(se[1]));
  cr_gray2bin_pipe #(.pWidth(8), .pStages(3), .pCheck(1'b1)) u_w8s3 (
    .Clk(clk), .Rst(rst), .InValid(iv[2]), .InReady(ir[2]), .G(g[2]),
    .OutValid(ov[2]), .OutReady(ordy[2]), .B(bo[2]), .StepErr(se[2]));
  cr_gray2bin_pipe #(.pWidth(8), .pStages(8), .pCheck(1'b1)) u_w8s8 (
    .Clk(clk), .Rst(rst), .InValid(iv[3]), .InReady(ir[3]), .G(g[3]),
    .OutValid(ov[3]), .OutReady(ordy[3]), .B(bo[3]), .StepErr(se[3]));

  // Reference model state
  ent_t       sb   [ND][$];
  logic [7:0] hist [ND];
  logic       hv   [ND];
  int         nacc [ND];
  logic [4:0] lg0  [$];
  logic       lat_mode;
  int         cyc;
  int         total;
  int         bad;

  function automatic int s_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  function automatic int w_of(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic logic [7:0] mask_of(input int d);
    return (d == 0) ? 8'h0f : 8'hff;
  endfunction

  // Binary value of a Gray word: XOR of all right shifts.
  function automatic logic [7:0] bin_of(input logic [7:0] gv, input int w);
    logic [7:0] r;
    r = 8'h00;
    for (int s = 0; s < w; s++) r = r ^ (gv >> s);
    return r;
  endfunction

  function automatic logic [7:0] gray_of(input logic [7:0] bv);
    return bv ^ (bv >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update model after it.
  task automatic step();
    logic       a  [ND];
    logic       o  [ND];
    logic       st [ND];
    logic [7:0] pb [ND];
    logic       pe [ND];
    logic [7:0] pg [ND];
    ent_t       e;
    logic [7:0] gv;
    #1;
    for (int d = 0; d < ND; d++) begin
      a[d]  = iv[d] && ir[d];
      o[d]  = ov[d] && ordy[d];
      st[d] = ov[d] && !ordy[d];
      pb[d] = bo[d];
      pe[d] = se[d];
      pg[d] = g[d];
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        sb[d].delete();
        hv[d]   = 1'b0;
        hist[d] = 8'h00;
      end else begin
        if (o[d]) begin
          chk($sformatf("out_has_entry%0d", d), 32'(sb[d].size() > 0), 32'd1);
          if (sb[d].size() > 0) begin
            e = sb[d].pop_front();
            chk($sformatf("b%0d", d), 32'(pb[d]), 32'(e.b));
            chk($sformatf("steperr%0d", d), 32'(pe[d]), 32'(e.err));
            if (e.lat) chk($sformatf("latency%0d", d), 32'(16'(cyc) - e.at), 32'(s_of(d)));
            if (d == 0) lg0.push_back({pe[0], pb[0][3:0]});
          end
        end
        if (st[d]) begin
          chk($sformatf("stall_b%0d", d), 32'(bo[d]), 32'(pb[d]));
          chk($sformatf("stall_err%0d", d), 32'(se[d]), 32'(pe[d]));
        end
        if (a[d]) begin
          gv    = pg[d] & mask_of(d);
          e.b   = bin_of(gv, w_of(d)) & mask_of(d);
          e.err = hv[d] && ($countones(gv ^ hist[d]) > 1);
          e.at  = 16'(cyc);
          e.lat = lat_mode;
          sb[d].push_back(e);
          hist[d] = gv;
          hv[d]   = 1'b1;
          nacc[d]++;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
    end
    step();
    rst = 1'b0;
    for (int d = 0; d < ND; d++) ordy[d] = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int d = 0; d < ND; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
    end
    repeat (n) step();
  endtask

  initial begin
    logic [3:0] t1w [5];
    logic [3:0] t3w [3];
    logic [4:0] t3e [3];
    logic [7:0] nb;
    bit         done;

    t1w = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    t3w = '{4'b0000, 4'b0011, 4'b0011};
    t3e = '{5'b0_0000, 5'b1_0010, 5'b0_0010};
    total = 0;
    bad = 0;
    cyc = 0;
    lat_mode = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; g[d] = 8'h00;
      hv[d] = 1'b0; hist[d] = 8'h00; nacc[d] = 0;
    end
    @(posedge clk);
    #1;
    step();
    step();

    // Reset state
    chk("rst_inready", 32'(ir[0]), 32'd0);
    for (int d = 0; d < ND; d++) chk($sformatf("rst_outvalid%0d", d), 32'(ov[d]), 32'd0);
    chk("rst_b", 32'(bo[0]), 32'd0);
    chk("rst_steperr", 32'(se[0]), 32'd0);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) ordy[d] = 1'b1;
    #1;
    chk("inready_after_rst", 32'(ir[0]), 32'd1);

    // T1: back-to-back stream, exact latency
    lat_mode = 1'b1;
    lg0.delete();
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1;
      g[0]  = {4'h0, t1w[i]};
      step();
    end
    drain(5);
    chk("t1_count", 32'(lg0.size()), 32'd5);
    for (int i = 0; i < 5 && i < lg0.size(); i++)
      chk($sformatf("t1_word%0d", i), 32'(lg0[i]), 32'(i));
    lat_mode = 1'b0;

    // T2: full Gray cycle then wrap
    do_reset();
    lg0.delete();
    for (int i = 0; i < 17; i++) begin
      iv[0] = 1'b1;
      g[0]  = gray_of(8'(i % 16));
      step();
    end
    drain(5);
    chk("t2_count", 32'(lg0.size()), 32'd17);
    for (int i = 0; i < 17 && i < lg0.size(); i++)
      chk($sformatf("t2_word%0d", i), 32'(lg0[i]), 32'(i % 16));

    // T3: two-bit jump flags, repeated word does not
    do_reset();
    lg0.delete();
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1;
      g[0]  = {4'h0, t3w[i]};
      step();
    end
    drain(5);
    chk("t3_count", 32'(lg0.size()), 32'd3);
    for (int i = 0; i < 3 && i < lg0.size(); i++)
      chk($sformatf("t3_word%0d", i), 32'(lg0[i]), 32'(t3e[i]));

    // T4: sink stalled while streaming, pipe fills to its depth
    for (int d = 0; d < ND; d++) begin
      nacc[d] = 0;
      ordy[d] = 1'b0;
      iv[d]   = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < ND; d++) g[d] = 8'($urandom);
      step();
    end
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("t4_accepts%0d", d), 32'(nacc[d]), 32'(s_of(d)));
      chk($sformatf("t4_inready%0d", d), 32'(ir[d]), 32'd0);
    end
    drain(12);
    for (int d = 0; d < ND; d++) chk($sformatf("t4_drained%0d", d), 32'(sb[d].size()), 32'd0);

    // T5: reset with words in flight, then first word after reset
    ordy[0] = 1'b0;
    iv[0]   = 1'b1;
    g[0]    = 8'h01;
    step();
    g[0]    = 8'h03;
    step();
    iv[0] = 1'b0;
    rst   = 1'b1;
    step();
    chk("t5_flush_outvalid", 32'(ov[0]), 32'd0);
    rst     = 1'b0;
    ordy[0] = 1'b1;
    g[0]    = 8'hxx;
    repeat (3) step();
    chk("t5_idle_outvalid", 32'(ov[0]), 32'd0);
    chk("t5_b_known", 32'($isunknown(bo[0])), 32'd0);
    lg0.delete();
    iv[0] = 1'b1;
    g[0]  = 8'h0f;
    step();
    drain(5);
    chk("t5_count", 32'(lg0.size()), 32'd1);
    if (lg0.size() > 0) chk("t5_word", 32'(lg0[0]), 32'b0_1010);

    // T6: random traffic on every instance
    for (int d = 0; d < ND; d++) nacc[d] = 0;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      for (int d = 0; d < ND; d++) begin
        iv[d]   = ($urandom % 4) != 0;
        ordy[d] = ($urandom % 3) != 0;
        case ($urandom % 3)
          0: g[d] = 8'($urandom);
          1: begin
            nb   = (bin_of(g[d] & mask_of(d), w_of(d)) + 8'd1) & mask_of(d);
            g[d] = gray_of(nb);
          end
          default: g[d] = g[d];
        endcase
      end
      step();
      done = 1'b1;
      for (int d = 0; d < ND; d++) if (nacc[d] < 2000) done = 1'b0;
    end
    for (int d = 0; d < ND; d++) chk($sformatf("t6_accepts%0d", d), 32'(nacc[d] >= 2000), 32'd1);

    // Exact latency with sink always ready
    drain(12);
    lat_mode = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int d = 0; d < ND; d++) begin
        iv[d] = 1'b1;
        g[d]  = 8'($urandom);
      end
      step();
    end
    drain(12);
    lat_mode = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("final_empty%0d", d), 32'(sb[d].size()), 32'd0);
      chk($sformatf("final_outvalid%0d", d), 32'(ov[d]), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
